// File: rtl/riscv_pkg.sv
// Shared RISC-V control-flow decode definitions: opcodes, branch condition
// codes and the control-flow class used by the branch resolve pipeline.
package riscv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        BC_BEQ  = 3'd0,
        BC_BNE  = 3'd1,
        BC_BLT  = 3'd4,
        BC_BGE  = 3'd5,
        BC_BLTU = 3'd6,
        BC_BGEU = 3'd7
    } branch_control_e;

    typedef enum logic [1:0] {
        CF_NONE   = 2'd0,
        CF_BRANCH = 2'd1,
        CF_JAL    = 2'd2,
        CF_JALR   = 2'd3
    } cf_class_e;

    function automatic cf_class_e decode_class(input logic [6:0] opcode);
        cf_class_e cls;
        case (opcode)
            OPC_BRANCH: cls = CF_BRANCH;
            OPC_JAL:    cls = CF_JAL;
            OPC_JALR:   cls = CF_JALR;
            default:    cls = CF_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation at full operand width.
// funct3 codes 2 and 3 have no branch meaning and are flagged illegal.
module branch_compare
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BC_BEQ:  taken = (rs1_val == rs2_val);
            BC_BNE:  taken = (rs1_val != rs2_val);
            BC_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            BC_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            BC_BLTU: taken = (rs1_val <  rs2_val);
            BC_BGEU: taken = (rs1_val >= rs2_val);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch/jump resolver: S1 holds decoded operands, S2 holds the
// resolved direction, target and link. The whole pipe stalls as one unit.
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1_val,
    input  logic [XLEN-1:0]  in_rs2_val,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_cf,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [CNT_W-1:0] taken_count
);

    logic advance;

    logic [6:0]      dec_opcode;
    logic [2:0]      dec_funct3;
    cf_class_e       dec_class;
    logic [12:0]     imm_b;
    logic [20:0]     imm_j;
    logic [11:0]     imm_i;
    logic [XLEN-1:0] dec_imm;

    logic            s1_valid_q, s1_valid_d;
    cf_class_e       s1_class_q, s1_class_d;
    logic [2:0]      s1_funct3_q, s1_funct3_d;
    logic [XLEN-1:0] s1_rs1_q, s1_rs1_d;
    logic [XLEN-1:0] s1_rs2_q, s1_rs2_d;
    logic [XLEN-1:0] s1_imm_q, s1_imm_d;
    logic [XLEN-1:0] s1_pc_q, s1_pc_d;
    logic            s1_pred_q, s1_pred_d;

    logic            cmp_taken;
    logic            cmp_illegal;
    logic            res_is_cf;
    logic            res_taken;
    logic            res_illegal;
    logic            res_mispredict;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_link;

    logic            s2_valid_q, s2_valid_d;
    logic            s2_is_cf_q, s2_is_cf_d;
    logic            s2_taken_q, s2_taken_d;
    logic            s2_illegal_q, s2_illegal_d;
    logic            s2_mispredict_q, s2_mispredict_d;
    logic [XLEN-1:0] s2_target_q, s2_target_d;
    logic [XLEN-1:0] s2_link_q, s2_link_d;

    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    // A result sitting in S2 that downstream refuses blocks both stages.
    assign advance  = !(s2_valid_q && !out_ready);
    assign in_ready = advance;

    always_comb begin
        dec_opcode = in_instr[6:0];
        dec_funct3 = in_instr[14:12];
        dec_class  = decode_class(dec_opcode);
        imm_b      = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        imm_j      = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        imm_i      = in_instr[31:20];
        case (dec_class)
            CF_BRANCH: dec_imm = {{(XLEN-13){imm_b[12]}}, imm_b};
            CF_JAL:    dec_imm = {{(XLEN-21){imm_j[20]}}, imm_j};
            CF_JALR:   dec_imm = {{(XLEN-12){imm_i[11]}}, imm_i};
            default:   dec_imm = '0;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_class_d  = s1_class_q;
        s1_funct3_d = s1_funct3_q;
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_imm_d    = s1_imm_q;
        s1_pc_d     = s1_pc_q;
        s1_pred_d   = s1_pred_q;
        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_class_d  = dec_class;
                s1_funct3_d = dec_funct3;
                s1_rs1_d    = in_rs1_val;
                s1_rs2_d    = in_rs2_val;
                s1_imm_d    = dec_imm;
                s1_pc_d     = in_pc;
                s1_pred_d   = in_pred_taken;
            end
        end
    end

    branch_compare #(
        .XLEN (XLEN)
    ) u_branch_compare (
        .rs1_val (s1_rs1_q),
        .rs2_val (s1_rs2_q),
        .funct3  (s1_funct3_q),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    always_comb begin
        res_is_cf   = 1'b0;
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        res_target  = '0;
        res_link    = s1_pc_q + XLEN'(4);
        case (s1_class_q)
            CF_BRANCH: begin
                res_is_cf   = 1'b1;
                res_taken   = cmp_taken;
                res_illegal = cmp_illegal;
                res_target  = s1_pc_q + s1_imm_q;
            end
            CF_JAL: begin
                res_is_cf  = 1'b1;
                res_taken  = 1'b1;
                res_target = s1_pc_q + s1_imm_q;
            end
            CF_JALR: begin
                res_is_cf  = 1'b1;
                res_taken  = 1'b1;
                res_target = (s1_rs1_q + s1_imm_q) & ~XLEN'(1);
            end
            default: ;
        endcase
        // An illegal branch never counts as a misprediction.
        res_mispredict = res_is_cf && !res_illegal && (res_taken != s1_pred_q);
    end

    always_comb begin
        s2_valid_d      = s2_valid_q;
        s2_is_cf_d      = s2_is_cf_q;
        s2_taken_d      = s2_taken_q;
        s2_illegal_d    = s2_illegal_q;
        s2_mispredict_d = s2_mispredict_q;
        s2_target_d     = s2_target_q;
        s2_link_d       = s2_link_q;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_is_cf_d      = res_is_cf;
                s2_taken_d      = res_taken;
                s2_illegal_d    = res_illegal;
                s2_mispredict_d = res_mispredict;
                s2_target_d     = res_target;
                s2_link_d       = res_link;
            end
        end
    end

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (s2_valid_q && out_ready && s2_taken_q && (taken_cnt_q != '1)) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q      <= 1'b0;
            s1_class_q      <= CF_NONE;
            s1_funct3_q     <= '0;
            s1_rs1_q        <= '0;
            s1_rs2_q        <= '0;
            s1_imm_q        <= '0;
            s1_pc_q         <= '0;
            s1_pred_q       <= 1'b0;
            s2_valid_q      <= 1'b0;
            s2_is_cf_q      <= 1'b0;
            s2_taken_q      <= 1'b0;
            s2_illegal_q    <= 1'b0;
            s2_mispredict_q <= 1'b0;
            s2_target_q     <= '0;
            s2_link_q       <= '0;
            taken_cnt_q     <= '0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_class_q      <= s1_class_d;
            s1_funct3_q     <= s1_funct3_d;
            s1_rs1_q        <= s1_rs1_d;
            s1_rs2_q        <= s1_rs2_d;
            s1_imm_q        <= s1_imm_d;
            s1_pc_q         <= s1_pc_d;
            s1_pred_q       <= s1_pred_d;
            s2_valid_q      <= s2_valid_d;
            s2_is_cf_q      <= s2_is_cf_d;
            s2_taken_q      <= s2_taken_d;
            s2_illegal_q    <= s2_illegal_d;
            s2_mispredict_q <= s2_mispredict_d;
            s2_target_q     <= s2_target_d;
            s2_link_q       <= s2_link_d;
            taken_cnt_q     <= taken_cnt_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_is_cf      = s2_is_cf_q;
    assign out_taken      = s2_taken_q;
    assign out_illegal    = s2_illegal_q;
    assign out_mispredict = s2_mispredict_q;
    assign out_target     = s2_target_q;
    assign out_link       = s2_link_q;
    assign taken_count    = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push hand-computed
// results into a queue; a negedge monitor pops and compares on each handshake.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        in_pred_taken;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_cf;
    logic        out_taken;
    logic [31:0] out_target;
    logic [31:0] out_link;
    logic        out_mispredict;
    logic        out_illegal;
    logic [1:0]  taken_count;

    typedef struct {
        logic        is_cf;
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_err;
    int   exp_cnt;

    logic        stall_prev;
    logic        h_is_cf, h_taken, h_mis, h_ill;
    logic [31:0] h_target, h_link;

    branch_resolve_unit #(
        .XLEN  (32),
        .CNT_W (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .in_rs1_val     (in_rs1_val),
        .in_rs2_val     (in_rs2_val),
        .in_pred_taken  (in_pred_taken),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_is_cf      (out_is_cf),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_link       (out_link),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal),
        .taken_count    (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic exp_t mk(input logic is_cf, input logic taken, input logic [31:0] target,
                                input logic [31:0] link, input logic mis, input logic ill);
        exp_t e;
        e.is_cf  = is_cf;
        e.taken  = taken;
        e.target = target;
        e.link   = link;
        e.mis    = mis;
        e.ill    = ill;
        return e;
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, opc};
    endfunction

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic pred, input exp_t e);
        bit ok;
        in_instr      = instr;
        in_pc         = pc;
        in_rs1_val    = rs1;
        in_rs2_val    = rs2;
        in_pred_taken = pred;
        in_valid      = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        chk("drain_done", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_cnt    = 0;
            stall_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                chk("taken_count", 32'(taken_count), 32'(exp_cnt));
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got out_valid=1 with target 0x%0h, required no result", out_target);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_is_cf",      32'(out_is_cf),      32'(e.is_cf));
                    chk("out_taken",      32'(out_taken),      32'(e.taken));
                    chk("out_target",     out_target,          e.target);
                    chk("out_link",       out_link,            e.link);
                    chk("out_mispredict", 32'(out_mispredict), 32'(e.mis));
                    chk("out_illegal",    32'(out_illegal),    32'(e.ill));
                    if (e.taken && exp_cnt != 3) exp_cnt++;
                end
            end
            if (out_valid && !out_ready) begin
                if (stall_prev) begin
                    chk("hold_is_cf",  32'(out_is_cf),      32'(h_is_cf));
                    chk("hold_taken",  32'(out_taken),      32'(h_taken));
                    chk("hold_target", out_target,          h_target);
                    chk("hold_link",   out_link,            h_link);
                    chk("hold_mis",    32'(out_mispredict), 32'(h_mis));
                    chk("hold_ill",    32'(out_illegal),    32'(h_ill));
                end
                h_is_cf    = out_is_cf;
                h_taken    = out_taken;
                h_target   = out_target;
                h_link     = out_link;
                h_mis      = out_mispredict;
                h_ill      = out_illegal;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        exp_cnt       = 0;
        stall_prev    = 1'b0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_instr      = '0;
        in_pc         = '0;
        in_rs1_val    = '0;
        in_rs2_val    = '0;
        in_pred_taken = 1'b0;
        out_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid",   32'(out_valid),      32'd0);
        chk("rst_out_taken",   32'(out_taken),      32'd0);
        chk("rst_out_mis",     32'(out_mispredict), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal),    32'd0);
        chk("rst_out_is_cf",   32'(out_is_cf),      32'd0);
        chk("rst_out_target",  out_target,          32'd0);
        chk("rst_out_link",    out_link,            32'd0);
        chk("rst_taken_count", 32'(taken_count),    32'd0);
        chk("rst_in_ready",    32'(in_ready),       32'd1);

        // BEQ 5==5, pc 0x100, imm +8, predicted not taken; also checks latency
        send(enc_b(3'd0, 13'h008), 32'h100, 32'd5, 32'd5, 1'b0, mk(1, 1, 32'h108, 32'h104, 1, 0));
        @(negedge clk);
        chk("latency_s1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_s2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        send(enc_b(3'd1, 13'h008),  32'h100, 32'd5,        32'd5,        1'b0, mk(1, 0, 32'h108, 32'h104, 0, 0));
        send(enc_b(3'd4, 13'h1ff0), 32'h200, 32'hFFFFFFFF, 32'd1,        1'b1, mk(1, 1, 32'h1F0, 32'h204, 0, 0));
        send(enc_b(3'd6, 13'h1ff0), 32'h200, 32'hFFFFFFFF, 32'd1,        1'b1, mk(1, 0, 32'h1F0, 32'h204, 1, 0));
        send(enc_b(3'd5, 13'h020),  32'h300, 32'd1,        32'hFFFFFFFF, 1'b0, mk(1, 1, 32'h320, 32'h304, 1, 0));
        send(enc_b(3'd7, 13'h020),  32'h300, 32'd1,        32'hFFFFFFFF, 1'b0, mk(1, 0, 32'h320, 32'h304, 0, 0));
        send(enc_i(7'b1100111, 12'h004), 32'h400, 32'h203, 32'd0, 1'b0, mk(1, 1, 32'h206, 32'h404, 1, 0));
        send(enc_j(21'h1ffffc), 32'h10, 32'd0, 32'd0, 1'b1, mk(1, 1, 32'hC, 32'h14, 0, 0));
        send(enc_b(3'd2, 13'h008),  32'h500, 32'd0, 32'd0, 1'b1, mk(1, 0, 32'h508, 32'h504, 0, 1));
        send(enc_b(3'd3, 13'h008),  32'h500, 32'd7, 32'd7, 1'b0, mk(1, 0, 32'h508, 32'h504, 0, 1));
        send(enc_i(7'b0010011, 12'h005), 32'h600, 32'd9, 32'd0, 1'b1, mk(0, 0, 32'h0, 32'h604, 0, 0));
        send(enc_j(21'h000010), 32'hFFFFFFF8, 32'd0, 32'd0, 1'b1, mk(1, 1, 32'h8, 32'hFFFFFFFC, 0, 0));
        drain();

        // Three back-to-back bundles with a downstream stall after the first result
        fork
            begin
                send(enc_j(21'h000008),    32'h1000, 32'd0, 32'd0, 1'b1, mk(1, 1, 32'h1008, 32'h1004, 0, 0));
                send(enc_b(3'd0, 13'h010), 32'h2000, 32'd7, 32'd7, 1'b0, mk(1, 1, 32'h2010, 32'h2004, 1, 0));
                send(enc_b(3'd1, 13'h010), 32'h3000, 32'd7, 32'd7, 1'b0, mk(1, 0, 32'h3010, 32'h3004, 0, 0));
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1;
                        break;
                    end
                end
                chk("b2b_first_result", 32'(seen), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready",  32'(in_ready),  32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two bundles in flight and a simultaneous offer
        out_ready = 1'b0;
        send(enc_j(21'h000008), 32'h4000, 32'd0, 32'd0, 1'b0, mk(1, 1, 32'h4008, 32'h4004, 1, 0));
        send(enc_j(21'h000008), 32'h5000, 32'd0, 32'd0, 1'b0, mk(1, 1, 32'h5008, 32'h5004, 1, 0));
        in_instr = enc_j(21'h000008);
        in_pc    = 32'h6000;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        sb_q.delete();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Saturation of the 2-bit taken counter over five taken jumps
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(enc_j(21'h000008), 32'(k * 16), 32'd0, 32'd0, 1'b1,
                 mk(1, 1, 32'(k * 16 + 8), 32'(k * 16 + 4), 0, 0));
        end
        drain();
        chk("taken_count_sat", 32'(taken_count), 32'd3);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/PC width (32 or 64 only).
REQ-002 SHALL have parameter CNT_W, default 16, meaning taken-counter width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning an instruction bundle is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the bundle is accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_instr, input, 32, meaning full RV32 instruction word.
REQ-008 SHALL have port in_pc, input, XLEN, meaning instruction PC.
REQ-009 SHALL have ports in_rs1_val and in_rs2_val, input, XLEN each, meaning source operand values.
REQ-010 SHALL have port in_pred_taken, input, 1, meaning front-end prediction.
REQ-011 SHALL have port out_valid, output, 1, meaning a result is presented.
REQ-012 SHALL have port out_ready, input, 1, meaning downstream consumes the result.
REQ-013 SHALL have port out_is_cf, output, 1, meaning the instruction is BRANCH, JAL or JALR.
REQ-014 SHALL have port out_taken, output, 1, meaning resolved direction.
REQ-015 SHALL have port out_target, output, XLEN, meaning resolved target address.
REQ-016 SHALL have port out_link, output, XLEN, meaning in_pc+4.
REQ-017 SHALL have port out_mispredict, output, 1, meaning out_taken differs from in_pred_taken, qualified by out_is_cf.
REQ-018 SHALL have port out_illegal, output, 1, meaning BRANCH with funct3 2 or 3.
REQ-019 SHALL have port taken_count, output, CNT_W, meaning saturating count of taken control-flow results delivered.

Function
REQ-020 SHALL be a two-stage pipeline: S1 registers decode (opcode class, branch_control, rs1/rs2 values, sign-extended imm, pc, prediction); S2 registers compare/target results.
REQ-021 SHALL deliver a result exactly 2 cycles after acceptance when out_ready stays high; throughput one per cycle.
REQ-022 SHALL advance the whole pipe only when !(s2_valid && !out_ready); in_ready equals that advance condition, combinationally.
REQ-023 SHALL hold all S1/S2 contents stable while stalled; out_* SHALL not change while out_valid && !out_ready.
REQ-024 SHALL decode opcode 1100011 as BRANCH, 1101111 as JAL, 1100111 as JALR; any other opcode gives out_is_cf=0, out_taken=0, out_mispredict=0, out_target=0.
REQ-025 SHALL map BRANCH funct3 0/1/4/5/6/7 to BEQ/BNE/BLT/BGE/BLTU/BGEU; BLT/BGE signed, BLTU/BGEU unsigned, all at full XLEN.
REQ-026 SHALL treat funct3 2/3 as illegal: out_illegal=1, out_taken=0, out_mispredict=0.
REQ-027 SHALL form immediates: B = {i[31],i[7],i[30:25],i[11:8],0}; J = {i[31],i[19:12],i[20],i[30:21],0}; I = i[31:20]; each sign-extended to XLEN.
REQ-028 SHALL compute target: BRANCH/JAL = pc+imm; JALR = (rs1+imm) with bit 0 cleared; all additions modulo 2^XLEN (wrap, no flag).
REQ-029 SHALL set out_taken=1 for JAL and JALR unconditionally; BRANCH per comparison.
REQ-030 SHALL present out_target even when BRANCH not taken.
REQ-031 SHALL increment taken_count on each out_valid&&out_ready&&out_taken cycle, saturating at all-ones.

Reset
REQ-032 SHALL on rst clear S1/S2 valid bits, giving out_valid=0, out_taken=0, out_mispredict=0, out_illegal=0, out_is_cf=0, out_target=0, out_link=0, taken_count=0.
REQ-033 SHALL discard in-flight bundles when rst asserts mid-operation; in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-034 SHALL give rst priority over any simultaneous handshake.

Structure
REQ-035 SHALL place branch_control enum (BEQ=0,BNE=1,BLT=4,BGE=5,BLTU=6,BGEU=7), opcode constants and cf-class enum in shared package riscv_pkg.
REQ-036 SHALL implement the comparison as sub-module branch_compare (XLEN-parametrised, combinational) instantiated in S2.

Verification
REQ-037 BEQ, rs1=rs2=5, pc=0x100, imm=+8, pred=0 -> 2 cycles later out_taken=1, out_target=0x108, out_mispredict=1.
REQ-038 BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken, target still driven.
REQ-039 JALR rs1=0x203, imm=+4 -> out_target=0x206, out_link=pc+4, out_taken=1.
REQ-040 Back-to-back 3 bundles, out_ready low 4 cycles after first result -> in_ready low, outputs frozen, all 3 delivered in order.
REQ-041 BRANCH funct3=2 -> out_illegal=1, out_taken=0; rst asserted with 2 bundles in flight -> no out_valid afterwards.
REQ-042 CNT_W=2, 5 taken results -> taken_count 1,2,3,3,3.
